// File: rtl/encode.sv
// RV32I field-bundle encoder feeding a 2-entry {instr, err} FIFO; one-cycle latency, in_ready drops only when FULL.
// Optional immediate range checking is enabled with ENCODE_RANGE_CHECK_EN.
module encode (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic        err,
  output logic [15:0] instr_count
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  logic [31:0] enc_instr;
  logic        enc_err;
  logic        word_err;
  logic        is_shift;

  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    enc_instr = NOP;
    enc_err   = 1'b0;
    case (opcode)
      OP_R:
        enc_instr = {funct7, rs2, rs1, funct3, rd, opcode};
      OP_IMM:
        if (is_shift) enc_instr = {funct7, imm[4:0], rs1, funct3, rd, opcode};
        else          enc_instr = {imm[11:0], rs1, funct3, rd, opcode};
      OP_JALR, OP_LOAD, OP_SYSTEM:
        enc_instr = {imm[11:0], rs1, funct3, rd, opcode};
      OP_STORE:
        enc_instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      OP_BRANCH:
        enc_instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      OP_LUI, OP_AUIPC:
        enc_instr = {imm[31:12], rd, opcode};
      OP_JAL:
        enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: begin
        enc_instr = NOP;
        enc_err   = 1'b1;
      end
    endcase
  end

`ifdef ENCODE_RANGE_CHECK_EN
  logic rng_err;
  logic imm_s12;
  logic imm_s13;
  logic imm_s21;

  // Immediate must be the sign extension of its encodable field width.
  assign imm_s12 = (imm[31:11] == {21{imm[11]}});
  assign imm_s13 = (imm[31:12] == {20{imm[12]}});
  assign imm_s21 = (imm[31:20] == {12{imm[20]}});

  always_comb begin
    rng_err = 1'b0;
    case (opcode)
      OP_IMM:                                rng_err = is_shift ? (|imm[31:5]) : !imm_s12;
      OP_JALR, OP_LOAD, OP_SYSTEM, OP_STORE: rng_err = !imm_s12;
      OP_BRANCH:                             rng_err = !imm_s13 || imm[0];
      OP_LUI, OP_AUIPC:                      rng_err = |imm[11:0];
      OP_JAL:                                rng_err = !imm_s21 || imm[0];
      default:                               rng_err = 1'b0;
    endcase
  end

  assign word_err = enc_err | rng_err;
`else
  assign word_err = enc_err;
`endif

  state_e      state_q, state_d;
  logic [32:0] head_q, head_d;
  logic [32:0] tail_q, tail_d;
  logic [15:0] count_q, count_d;
  logic [32:0] new_word;
  logic        push;
  logic        pop;

  assign new_word    = {enc_instr, word_err};
  assign out_valid   = (state_q != EMPTY);
  // Held low while reset is asserted even though the state register already reads EMPTY.
  assign in_ready    = rst_n && (state_q != FULL);
  assign push        = in_valid && in_ready;
  assign pop         = out_valid && out_ready;
  assign instr       = head_q[32:1];
  assign err         = head_q[0];
  assign instr_count = count_q;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + {15'd0, pop};
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          head_d  = new_word;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = new_word;
        end else if (push) begin
          state_d = FULL;
          tail_d  = new_word;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_d = ONE;
          head_d  = tail_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_encode.sv
// Bench for encode: directed scenarios plus random traffic against an arithmetic reference model and a queue scoreboard.
module tb_encode;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic        err;
  logic [15:0] instr_count;

  encode dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .rs1(rs1), .rs2(rs2),
    .rd(rd), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
    .instr(instr), .err(err), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ENCODE_RANGE_CHECK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  int          tests;
  int          fails;
  logic [32:0] mq[$];
  logic [15:0] mcount;
  logic [6:0]  ops [10];

  // Reference encoding built from field weights with plain integer arithmetic.
  function automatic logic [32:0] ref_enc(input logic [6:0] opc, input logic [2:0] f3_in,
                                          input logic [6:0] f7_in, input logic [4:0] r1,
                                          input logic [4:0] r2, input logic [4:0] rdd,
                                          input logic [31:0] im);
    logic [31:0] w, o, d, f, a, b, g;
    int          s;
    bit          e, bad, i_bad;
    o = 32'(opc); d = 32'(rdd); f = 32'(f3_in); a = 32'(r1); b = 32'(r2); g = 32'(f7_in);
    s = $signed(im);
    e = 1'b0;
    bad = 1'b0;
    i_bad = (s < -2048) || (s > 2047);
    case (opc)
      7'h33: w = o + (d << 7) + (f << 12) + (a << 15) + (b << 20) + (g << 25);
      7'h13: begin
        if (f3_in == 3'd1 || f3_in == 3'd5) begin
          w = o + (d << 7) + (f << 12) + (a << 15) + ((im % 32) << 20) + (g << 25);
          bad = im > 31;
        end else begin
          w = o + (d << 7) + (f << 12) + (a << 15) + ((im % 4096) << 20);
          bad = i_bad;
        end
      end
      7'h67, 7'h03, 7'h73: begin
        w = o + (d << 7) + (f << 12) + (a << 15) + ((im % 4096) << 20);
        bad = i_bad;
      end
      7'h23: begin
        w = o + ((im % 32) << 7) + (f << 12) + (a << 15) + (b << 20) + (((im / 32) % 128) << 25);
        bad = i_bad;
      end
      7'h63: begin
        w = o + (((im / 2048) % 2) << 7) + (((im / 2) % 16) << 8) + (f << 12) + (a << 15)
              + (b << 20) + (((im / 32) % 64) << 25) + (((im / 4096) % 2) << 31);
        bad = (s < -4096) || (s > 4095) || (im % 2 != 0);
      end
      7'h37, 7'h17: begin
        w = o + (d << 7) + (im - (im % 4096));
        bad = (im % 4096) != 0;
      end
      7'h6F: begin
        w = o + (d << 7) + (((im / 4096) % 256) << 12) + (((im / 2048) % 2) << 20)
              + (((im / 2) % 1024) << 21) + (((im / 1048576) % 2) << 31);
        bad = (s < -1048576) || (s > 1048575) || (im % 2 != 0);
      end
      default: begin
        w = 32'h0000_0013;
        e = 1'b1;
      end
    endcase
    e = e || (RANGE_CHK && bad);
    return {w, e};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [6:0] o, input logic [2:0] f3_in,
                       input logic [6:0] f7_in, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rdd, input logic [31:0] im);
    in_valid = v; opcode = o; funct3 = f3_in; funct7 = f7_in;
    rs1 = r1; rs2 = r2; rd = rdd; imm = im;
  endtask

  task automatic check_state();
    chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("instr_count", 32'(instr_count), 32'(mcount));
    if (mq.size() != 0) begin
      chk("head_instr", instr, mq[0][32:1]);
      chk("head_err", 32'(err), 32'(mq[0][0]));
    end
  endtask

  // Check the visible state, then advance one clock and apply the handshakes to the model.
  task automatic cycle();
    bit          push, pop;
    logic [32:0] word;
    check_state();
    push = in_valid && (mq.size() < 2);
    pop  = out_ready && (mq.size() != 0);
    word = ref_enc(opcode, funct3, funct7, rs1, rs2, rd, imm);
    @(posedge clk);
    #1;
    if (pop) begin
      void'(mq.pop_front());
      mcount++;
    end
    if (push) mq.push_back(word);
  endtask

  initial begin
    int          k;
    int          m;
    logic [6:0]  o;
    logic [31:0] im;

    tests = 0;
    fails = 0;
    mcount = 16'd0;
    ops = '{7'h33, 7'h13, 7'h67, 7'h03, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
    rst_n = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 7'h0, 3'h0, 7'h0, 5'd0, 5'd0, 5'd0, 32'h0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // addi x1, x0, 5
    drive(1'b1, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5);
    cycle();
    drive(1'b0, 7'h0, 3'h0, 7'h0, 5'd0, 5'd0, 5'd0, 32'h0);
    chk("addi_valid", 32'(out_valid), 32'd1);
    chk("addi_instr", instr, 32'h0050_0093);
    chk("addi_err", 32'(err), 32'd0);
    out_ready = 1'b1;
    cycle();

    // add x3,x1,x2 then sw x2,8(x1) back to back
    drive(1'b1, 7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0);
    cycle();
    chk("add_instr", instr, 32'h0020_81B3);
    drive(1'b1, 7'h23, 3'd2, 7'd0, 5'd1, 5'd2, 5'd0, 32'd8);
    cycle();
    chk("sw_instr", instr, 32'h0020_A423);
    drive(1'b0, 7'h0, 3'h0, 7'h0, 5'd0, 5'd0, 5'd0, 32'h0);
    cycle();
    chk("count_after_three", 32'(instr_count), 32'd3);

    // beq x0,x0,-4 then a misaligned branch offset
    out_ready = 1'b0;
    drive(1'b1, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC);
    cycle();
    chk("beq_instr", instr, 32'hFE00_0EE3);
    chk("beq_err", 32'(err), 32'd0);
    drive(1'b1, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'h0000_0003);
    cycle();
    drive(1'b0, 7'h0, 3'h0, 7'h0, 5'd0, 5'd0, 5'd0, 32'h0);
    out_ready = 1'b1;
    cycle();
    chk("beq_odd_err", 32'(err), 32'(RANGE_CHK));
    cycle();

    // Three bundles offered with the consumer stalled
    out_ready = 1'b0;
    drive(1'b1, 7'h37, 3'd0, 7'd0, 5'd0, 5'd0, 5'd5, 32'hABCD_E000);
    cycle();
    drive(1'b1, 7'h6F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'h0000_0800);
    cycle();
    chk("full_in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 7'h13, 3'd1, 7'd0, 5'd4, 5'd0, 5'd6, 32'd7);
    cycle();
    cycle();
    out_ready = 1'b1;
    cycle();
    cycle();
    drive(1'b0, 7'h0, 3'h0, 7'h0, 5'd0, 5'd0, 5'd0, 32'h0);
    cycle();
    chk("stall_drained", 32'(mq.size()), 32'd0);
    cycle();

    // Unknown opcode, then reset while FULL
    out_ready = 1'b0;
    drive(1'b1, 7'h7F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'h0);
    cycle();
    chk("nop_instr", instr, 32'h0000_0013);
    chk("nop_err", 32'(err), 32'd1);
    drive(1'b1, 7'h33, 3'd0, 7'd32, 5'd9, 5'd10, 5'd11, 32'h0);
    cycle();
    chk("full_valid", 32'(out_valid), 32'd1);
    drive(1'b0, 7'h0, 3'h0, 7'h0, 5'd0, 5'd0, 5'd0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_count", 32'(instr_count), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_instr", instr, 32'd0);
    mq.delete();
    mcount = 16'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    cycle();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      k = $urandom_range(0, 10);
      o = (k == 10) ? 7'($urandom) : ops[k];
      m = $urandom_range(0, 2);
      if (m == 0)      im = $urandom;
      else if (m == 1) im = 32'($urandom_range(0, 8191)) - 32'd4096;
      else             im = $urandom & 32'hFFFF_F01F;
      drive(1'($urandom), o, 3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom),
            5'($urandom), im);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    drive(1'b0, 7'h0, 3'h0, 7'h0, 5'd0, 5'd0, 5'd0, 32'h0);
    out_ready = 1'b1;
    repeat (3) cycle();
    chk("final_empty", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/encode.md
ENCODE -- requirements
Module: encode

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous active-low reset.
REQ-003 in_valid  input  1  field bundle on opcode..imm is valid.
REQ-004 in_ready  output  1  encoder can accept a bundle this cycle.
REQ-005 opcode  input  7  RV32I major opcode.
REQ-006 funct3  input  3  funct3 field.
REQ-007 funct7  input  7  funct7 field (R-type and OP-IMM shifts only).
REQ-008 rs1, rs2, rd  input  5 each  register indices.
REQ-009 imm  input  32  sign-extended immediate in the same layout the decode stage produces.
REQ-010 out_valid  output  1  instr/err hold a valid encoded word.
REQ-011 out_ready  input  1  consumer accepts the word this cycle.
REQ-012 instr  output  32  encoded instruction word.
REQ-013 err  output  1  bundle was not encodable (sideband of instr).
REQ-014 instr_count  output  16  count of words delivered on the output handshake.

Function
REQ-015 Input transfer on in_valid&in_ready; output transfer on out_valid&out_ready.
REQ-016 Encoding is combinational on the inputs; the result is written into a 2-entry FIFO of {instr, err}; the FIFO head drives instr/err.
REQ-017 Latency: a bundle accepted in cycle N is at the FIFO head, with out_valid=1, in cycle N+1 at the earliest; FIFO order is preserved.
REQ-018 FIFO states are EMPTY, ONE, FULL; out_valid=(state!=EMPTY); in_ready=(state!=FULL); in_ready does not depend on out_ready.
REQ-019 Transitions: push only -> count+1; pop only -> count-1; simultaneous push and pop in ONE -> stays ONE, with the new word at the head next cycle.
REQ-020 In FULL, in_valid is ignored; in EMPTY, out_ready is ignored; instr/err are held stable while out_valid&!out_ready.
REQ-021 0110011 (R): funct7|rs2|rs1|funct3|rd|opcode.
REQ-022 0010011 with funct3 001/101: funct7|imm[4:0]|rs1|funct3|rd|opcode; other funct3: imm[11:0]|rs1|funct3|rd|opcode.
REQ-023 1100111, 0000011, 1110011 (I): imm[11:0]|rs1|funct3|rd|opcode.
REQ-024 0100011 (S): imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
REQ-025 1100011 (B): imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
REQ-026 0110111, 0010111 (U): imm[31:12]|rd|opcode.
REQ-027 1101111 (J): imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
REQ-028 Any other opcode: instr=32'h00000013 (NOP), err=1.
REQ-029 instr_count increments by 1 on each output transfer and wraps from 16'hFFFF to 16'h0000.

Reset
REQ-030 rst_n low immediately forces the FIFO to EMPTY, out_valid=0, err=0, instr=0, instr_count=0, and in_ready=0 while rst_n is low.
REQ-031 in_ready=1 in the first cycle after rst_n deasserts.
REQ-032 Reset mid-transfer discards all FIFO contents; no partial word is delivered.

Configuration
REQ-033 With ENCODE_RANGE_CHECK_EN defined, err=1 is also raised for an encodable opcode when:
  - I/S/OP-IMM (non-shift) imm is not a 12-bit sign extension;
  - shift imm[31:5]!=0;
  - B imm is not 13-bit signed or imm[0]=1;
  - J imm is not 21-bit signed or imm[0]=1;
  - U imm[11:0]!=0.
  The encoded bits are still produced per REQ-021..027.
REQ-034 Without ENCODE_RANGE_CHECK_EN, err=1 only for REQ-028; out-of-range bits are silently truncated.

Verification
REQ-035 opcode=0010011, f3=0, rs1=0, rd=1, imm=5 -> instr=32'h00500093, err=0, one cycle later.
REQ-036 Back-to-back add x3,x1,x2, then sw x2,8(x1), with out_ready=1 -> 32'h002081B3, then 32'h0020A423; instr_count=2.
REQ-037 beq x0,x0, imm=32'hFFFFFFFC -> 32'hFE000EE3; with the macro, imm=32'h00000003 -> err=1.
REQ-038 out_ready=0, three bundles offered -> in_ready=0 after two accepted; releasing out_ready delivers the words in order, then the third is accepted.
REQ-039 opcode=7'b1111111 -> instr=32'h00000013, err=1; rst_n pulsed low while FULL -> out_valid=0 and instr_count=0 immediately.
